// File: rtl/hx2003_pulse_sequencer.sv
// Pulse transmitter symbol sequencer: FIFO of {level, duration}
// symbols played back-to-back on prescaler ticks.
module hx2003_pulse_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int DUR_W      = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DUR_W:0]               sym_data,
  input  logic                         sym_valid,
  output logic                         sym_ready,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         tick,
  input  logic                         carrier_in,
  input  logic                         carrier_en,
  input  logic                         idle_level,
  input  logic                         invert,
  output logic                         pulse_out,
  output logic                         busy,
  output logic                         done,
  output logic                         underflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LP_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [DUR_W-1:0] LP_ONE = DUR_W'(1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [DUR_W:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic [DUR_W-1:0] r_dur;
  logic             r_level;
  logic             r_done;
  logic             r_uf;

  logic             w_push;
  logic             w_pop;
  logic             w_load;
  logic             w_dec;
  logic             w_done;
  logic             w_uf_set;
  logic             w_uf_clr;
  logic             w_empty;
  logic             w_head_end;
  logic [DUR_W:0]   w_head;
  logic             w_busy;

  assign w_empty    = (r_count == '0);
  assign w_head     = r_mem[r_rptr];
  assign w_head_end = (w_head[DUR_W-1:0] == '0);
  assign sym_ready  = (r_count < LP_FULL);
  assign w_push     = sym_valid & sym_ready & ~abort;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_pop    = 1'b0;
    w_load   = 1'b0;
    w_dec    = 1'b0;
    w_done   = 1'b0;
    w_uf_set = 1'b0;
    w_uf_clr = 1'b0;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start && !w_empty) begin
            w_pop = 1'b1;
            if (w_head_end) begin
              w_done = 1'b1;
            end else begin
              w_load   = 1'b1;
              w_uf_clr = 1'b1;
              w_next   = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (tick) begin
            if (r_dur > LP_ONE) begin
              w_dec = 1'b1;
            end else if (w_empty) begin
              // ran dry without an end marker
              w_next   = S_IDLE;
              w_uf_set = 1'b1;
              w_done   = 1'b1;
            end else if (w_head_end) begin
              w_pop  = 1'b1;
              w_next = S_IDLE;
              w_done = 1'b1;
            end else begin
              w_pop  = 1'b1;
              w_load = 1'b1;
            end
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_busy = (r_state == S_RUN);
    if (w_busy)
      pulse_out = invert ^
        (r_level & (carrier_en ? carrier_in : 1'b1));
    else
      pulse_out = invert ^ idle_level;
  end

  assign busy       = w_busy;
  assign done       = r_done;
  assign underflow  = r_uf;
  assign fifo_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= sym_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_dur   <= '0;
      r_level <= 1'b0;
      r_done  <= 1'b0;
      r_uf    <= 1'b0;
    end else begin
      r_done <= w_done;
      if (w_uf_set)      r_uf <= 1'b1;
      else if (w_uf_clr) r_uf <= 1'b0;
      if (abort) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
        r_dur   <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop)  r_rptr <= r_rptr + AW'(1);
        r_count <= r_count + (AW+1)'(w_push)
                           - (AW+1)'(w_pop);
        if (w_load) begin
          r_level <= w_head[DUR_W];
          r_dur   <= w_head[DUR_W-1:0];
        end else if (w_dec) begin
          r_dur <= r_dur - LP_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_hx2003_pulse_sequencer.sv
// Directed bench for hx2003_pulse_sequencer with a per-cycle
// expected-waveform scoreboard.
module tb_hx2003_pulse_sequencer;

  localparam int DEPTH = 8;
  localparam int DW    = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW:0]   sym_data = '0;
  logic          sym_valid = 1'b0;
  logic          sym_ready;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          tick = 1'b0;
  logic          carrier_in = 1'b0;
  logic          carrier_en = 1'b0;
  logic          idle_level = 1'b0;
  logic          invert = 1'b0;
  logic          pulse_out;
  logic          busy;
  logic          done;
  logic          underflow;
  logic [3:0]    fifo_count;
  int            ccnt = 0;

  hx2003_pulse_sequencer #(
    .FIFO_DEPTH(DEPTH),
    .DUR_W(DW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sym_data(sym_data),
    .sym_valid(sym_valid),
    .sym_ready(sym_ready),
    .start(start),
    .abort(abort),
    .tick(tick),
    .carrier_in(carrier_in),
    .carrier_en(carrier_en),
    .idle_level(idle_level),
    .invert(invert),
    .pulse_out(pulse_out),
    .busy(busy),
    .done(done),
    .underflow(underflow),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // carrier toggles every 2 cycles
  always @(posedge clk) begin
    if (ccnt == 1) begin
      carrier_in <= ~carrier_in;
      ccnt <= 0;
    end else begin
      ccnt <= ccnt + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct packed {
    logic carr;
    logic pv;
    logic b;
    logic d;
    logic u;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    assert (got === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, got, want);
    end
  endtask

  function automatic logic [DW:0] sym(input logic l,
                                      input int d);
    return {l, d[DW-1:0]};
  endfunction

  task automatic exp_seg(input int n, input logic carr,
                         input logic pv, input logic b,
                         input logic d, input logic u);
    exp_t e;
    e.carr = carr;
    e.pv = pv;
    e.b = b;
    e.d = d;
    e.u = u;
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW:0] d);
    sym_data = d;
    sym_valid = 1'b1;
    step();
    sym_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // drive ticks every per cycles and pop one expectation per cycle
  task automatic play(input int per);
    int k;
    exp_t e;
    logic pv;
    k = 0;
    while (q.size() > 0) begin
      k++;
      tick = ((k % per) == 0);
      @(negedge clk);
      e = q.pop_front();
      pv = e.carr ? (e.pv ^ carrier_in) : e.pv;
      chk($sformatf("wave c%0d {pulse,busy,done,uf}", k),
          {pulse_out, busy, done, underflow},
          {pv, e.b, e.d, e.u});
      step();
    end
    tick = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst pulse_out", pulse_out, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst underflow", underflow, 0);
    chk("rst fifo_count", fifo_count, 0);
    chk("rst sym_ready", sym_ready, 1);
    step();

    // basic playback
    push(sym(1, 3));
    push(sym(0, 2));
    push(sym(0, 0));
    @(negedge clk);
    chk("t1 count", fifo_count, 3);
    step();
    pulse_start();
    exp_seg(12, 0, 1, 1, 0, 0);
    exp_seg(8, 0, 0, 1, 0, 0);
    exp_seg(1, 0, 0, 0, 1, 0);
    exp_seg(3, 0, 0, 0, 0, 0);
    play(4);
    chk("t1 count end", fifo_count, 0);

    // carrier gating, then inverted
    carrier_en = 1'b1;
    push(sym(1, 4));
    push(sym(0, 4));
    push(sym(0, 0));
    pulse_start();
    exp_seg(16, 1, 0, 1, 0, 0);
    exp_seg(16, 0, 0, 1, 0, 0);
    exp_seg(1, 0, 0, 0, 1, 0);
    exp_seg(2, 0, 0, 0, 0, 0);
    play(4);
    invert = 1'b1;
    push(sym(1, 4));
    push(sym(0, 4));
    push(sym(0, 0));
    @(negedge clk);
    chk("t2 inv idle", pulse_out, 1);
    step();
    pulse_start();
    exp_seg(16, 1, 1, 1, 0, 0);
    exp_seg(16, 0, 1, 1, 0, 0);
    exp_seg(1, 0, 1, 0, 1, 0);
    exp_seg(2, 0, 1, 0, 0, 0);
    play(4);
    invert = 1'b0;
    carrier_en = 1'b0;

    // underflow
    push(sym(1, 2));
    pulse_start();
    exp_seg(8, 0, 1, 1, 0, 0);
    exp_seg(1, 0, 0, 0, 1, 1);
    exp_seg(2, 0, 0, 0, 0, 1);
    play(4);
    sym_data = sym(1, 3);
    sym_valid = 1'b1;
    abort = 1'b1;
    step();
    sym_valid = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("abort idle count", fifo_count, 0);
    chk("abort idle uf", underflow, 1);
    chk("abort idle done", done, 0);
    step();
    push(sym(1, 1));
    push(sym(0, 0));
    pulse_start();
    exp_seg(4, 0, 1, 1, 0, 0);
    exp_seg(1, 0, 0, 0, 1, 0);
    exp_seg(1, 0, 0, 0, 0, 0);
    play(4);

    // full FIFO backpressure
    for (int i = 0; i < DEPTH; i++) push(sym(0, 0));
    sym_data = sym(1, 5);
    sym_valid = 1'b1;
    @(negedge clk);
    chk("t4 full count", fifo_count, 8);
    chk("t4 full ready", sym_ready, 0);
    step();
    start = 1'b1;
    @(negedge clk);
    chk("t4 held count", fifo_count, 8);
    step();
    start = 1'b0;
    @(negedge clk);
    chk("t4 pop count", fifo_count, 7);
    chk("t4 pop ready", sym_ready, 1);
    chk("t4 pop done", done, 1);
    step();
    sym_valid = 1'b0;
    @(negedge clk);
    chk("t4 9th accepted", fifo_count, 8);
    step();
    for (int i = 0; i < DEPTH - 1; i++) begin
      pulse_start();
      @(negedge clk);
      chk($sformatf("t4 marker %0d done", i), done, 1);
      step();
    end
    chk("t4 last count", fifo_count, 1);
    pulse_start();
    @(negedge clk);
    chk("t4 9th busy", busy, 1);
    chk("t4 9th level", pulse_out, 1);
    chk("t4 9th count", fifo_count, 0);
    step();

    // abort mid-symbol with a push
    step();
    sym_data = sym(1, 3);
    sym_valid = 1'b1;
    abort = 1'b1;
    step();
    sym_valid = 1'b0;
    abort = 1'b0;
    exp_seg(6, 0, 0, 0, 0, 0);
    play(4);
    chk("t5 count", fifo_count, 0);
    pulse_start();
    @(negedge clk);
    chk("t5 empty start busy", busy, 0);
    chk("t5 empty start done", done, 0);
    step();

    // tick tied high, 1-tick symbols
    push(sym(1, 1));
    push(sym(0, 1));
    push(sym(1, 1));
    push(sym(0, 0));
    pulse_start();
    exp_seg(1, 0, 1, 1, 0, 0);
    exp_seg(1, 0, 0, 1, 0, 0);
    exp_seg(1, 0, 1, 1, 0, 0);
    exp_seg(1, 0, 0, 0, 1, 0);
    exp_seg(2, 0, 0, 0, 0, 0);
    play(1);
    chk("t6 count", fifo_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hx2003_pulse_sequencer.md
# hx2003_pulse_sequencer

Symbol sequencer that sits directly downstream of the pulse transmitter's carrier generator and prescalers. It buffers software-written symbols in a small FIFO. Each symbol is a {level, duration} pair, with duration counted in prescaler ticks. The block plays the symbols out back-to-back, optionally gating the carrier, to produce the final transmit waveform on the output pin.

## Interface

Parameters:
- FIFO_DEPTH, 8: symbol FIFO entries; must be a power of two, ≥2
- DUR_W, 15: duration field width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- sym_data  in  DUR_W+1  symbol: [DUR_W] level, [DUR_W-1:0] duration in ticks; duration 0 = end marker
- sym_valid  in  1  push request
- sym_ready  out  1  FIFO not full
- start  in  1  one-cycle start pulse
- abort  in  1  one-cycle abort pulse
- tick  in  1  one-cycle prescaler tick from the main prescaler
- carrier_in  in  1  registered carrier from the carrier generator
- carrier_en  in  1  1: level-1 symbols output the carrier; 0: output constant 1
- idle_level  in  1  line level when not busy
- invert  in  1  final output polarity inversion
- pulse_out  out  1  transmit waveform
- busy  out  1  high in RUN
- done  out  1  one-cycle completion pulse
- underflow  out  1  sticky: FIFO ran empty without an end marker
- fifo_count  out  log2(FIFO_DEPTH)+1  entries held

## Operation

- FIFO: register array with read and write pointers. The head entry is combinationally visible. Push when sym_valid && sym_ready. A push and pop in the same cycle leave the count unchanged. sym_ready = fifo_count < FIFO_DEPTH.
- FSM has two states, IDLE and RUN. Registers: state, level_reg, dur_cnt (DUR_W bits).
- IDLE + start:
  - FIFO empty: start ignored; no done, no state change.
  - Head is an end marker: pop it, stay IDLE, pulse done.
  - Otherwise: pop head, load level_reg and dur_cnt from it, go to RUN, clear underflow.
- RUN + tick:
  - dur_cnt > 1: decrement.
  - dur_cnt == 1: the symbol expires. Take the next action from the head in the same cycle:
    - Normal symbol: pop it, load it, stay RUN.
    - End marker: pop it, go to IDLE, pulse done.
    - FIFO empty: go to IDLE, set underflow, pulse done.
- A push landing in the same cycle as an expiry with an empty FIFO is not visible to that expiry. That case counts as underflow.
- start while in RUN is ignored.
- abort has highest priority in any state. Next cycle: IDLE, FIFO flushed (pointers and count to 0), dur_cnt 0, no done, underflow unchanged. A push or start in the abort cycle is dropped.
- pulse_out is combinational from registered state and the carrier:
  - RUN: invert ^ (level_reg & (carrier_en ? carrier_in : 1))
  - IDLE: invert ^ idle_level
- The first symbol after start is not tick-aligned. Its length is between (N-1) and N tick periods plus one cycle. Every later symbol lasts exactly N tick periods.

## Timing

- Reset values: state IDLE, FIFO empty, fifo_count 0, sym_ready 1, busy 0, done 0, underflow 0, dur_cnt 0, level_reg 0. pulse_out = invert ^ idle_level.
- start accepted at cycle t: busy and new level on pulse_out from t+1. fifo_count reflects the pop at t+1.
- Expiry on a tick at cycle t: the next symbol's level appears at t+1, with no gap cycle.
- done: asserted exactly one cycle, in the cycle after the transition decision (the same cycle busy falls). For an immediate end marker on start, done asserts at t+1.
- With tick held at 1, a duration-1 symbol occupies exactly one clock.
- dur_cnt never wraps: a loaded duration is always ≥1, and it is decremented only when >1.

## Test plan

1. Setup: idle_level=0, invert=0, carrier_en=0, tick every 4 cycles. Push {1,3}, {0,2}, marker, then start. Required: pulse_out high for 3 tick periods (first one partial), then low for 2 tick periods, then idle 0. done pulses once; underflow=0; fifo_count=0.
2. carrier_en=1, carrier_in toggling every 2 cycles, symbols {1,4}, {0,4}, marker. Required: pulse_out tracks carrier_in during the first symbol and is 0 during the second. With invert=1, the whole output is complemented, including idle (1).
3. Push {1,2} only, then start. Required: after 2 ticks, busy=0, done=1 for one cycle, underflow=1. Then push {1,1} plus marker and start: underflow clears at start+1.
4. FIFO_DEPTH=8, push 9 entries while IDLE. Required: sym_ready=0 after the 8th push, the 9th entry is held, fifo_count=8. After start, one pop occurs: count=7, sym_ready=1, and the 9th entry is accepted.
5. Abort mid-symbol, with a simultaneous sym_valid. Required: next cycle busy=0, fifo_count=0, pulse_out=idle_level, no done pulse, underflow unchanged, pushed entry dropped.
6. tick tied to 1, symbols {1,1}, {0,1}, {1,1}, marker. Required: pulse_out 1, 0, 1 for exactly one cycle each, then idle, with done in the cycle after the last symbol.
